// File: rtl/rr_decode_arbiter_pkg.sv
// Shared constants for the round-robin decode arbiter: state encoding, sizes,
// reset pointer and the rotating priority search.
package rr_decode_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [IDX_W-1:0] PTR_RST = 3'd7;

    // First set request strictly after the last owner, wrapping through 7 -> 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] cand;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last + IDX_W'(k);
            if (!found && req[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_decode_arbiter_onehot_dec3to8.sv
// Combinational 3-bit index to 8-bit one-hot decode; output is all zero
// whenever the enable is low.
module onehot_dec3to8
    import rr_decode_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter with encoded winner, one-hot grant and a
// mandatory turnaround cycle. Optional forced revocation under GRANT_TIMEOUT_EN.
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             busy,
    output logic             timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD must lie in 2..255");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] idx_q;
    logic             tmo;
    logic             exit_grant;
    logic             in_grant;

    assign in_grant = (state == ST_GRANT);

`ifdef GRANT_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == ST_IDLE) begin
            hold_cnt <= '0;
        end else if (in_grant) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    // Revocation only when the owner would otherwise keep the grant.
    assign tmo = in_grant && (hold_cnt == HOLD_LAST) && !done && req[idx_q];
`else
    assign tmo = 1'b0;
`endif

    assign exit_grant = done || !req[idx_q] || tmo;

    // idx_q doubles as the last-owner pointer: it is loaded on GRANT entry only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx_q <= PTR_RST;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        idx_q <= rr_pick(req, idx_q);
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (exit_grant) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    onehot_dec3to8 u_dec (
        .idx    (idx_q),
        .en     (in_grant),
        .onehot (gnt)
    );

    assign gnt_idx   = idx_q;
    assign gnt_valid = in_grant;
    assign busy      = (state != ST_IDLE);
    assign timeout   = tmo;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter: behavioural owner/gap model plus
// directed literal checks and randomized traffic. Honours GRANT_TIMEOUT_EN.
module tb_rr_decode_arbiter;

    localparam int MAX_HOLD = 16;
`ifdef GRANT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad = 0;

    rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Model: who owns the resource (-1 = nobody), whether we are in the
    // turnaround cycle, the last owner, and how long the owner has held it.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_last  = 7;
    int m_hold  = 0;

    function automatic int pick(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    function automatic bit m_tmo();
        return TMO_EN && (m_owner >= 0) && !done && req[m_owner] &&
               (m_hold == MAX_HOLD - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_gap   <= 1'b0;
            m_last  <= 7;
            m_hold  <= 0;
        end else if (m_owner >= 0) begin
            if (done || !req[m_owner] || m_tmo()) begin
                m_owner <= -1;
                m_gap   <= 1'b1;
            end else begin
                m_hold <= m_hold + 1;
            end
        end else if (m_gap) begin
            m_gap <= 1'b0;
        end else if (req != 8'h00) begin
            m_owner <= pick(req, m_last);
            m_last  <= pick(req, m_last);
            m_hold  <= 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
        chk("gnt_idx", int'(gnt_idx), m_last);
        chk("gnt_valid", int'(gnt_valid), int'(m_owner >= 0));
        chk("busy", int'(busy), int'((m_owner >= 0) || m_gap));
        chk("timeout", int'(timeout), int'(m_tmo()));
    endtask

    task automatic step(input logic [7:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        #1;
        compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_gnt"}, int'(gnt), 0);
        chk({tag, "_idx"}, int'(gnt_idx), 7);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(gnt_valid), 0);
    endtask

    initial begin
        int k;
        int run;
        bit seen;
        logic [7:0] r;

        do_reset();
        step(8'h00, 1'b0);
        chk("rst_idx", int'(gnt_idx), 7);
        chk("rst_busy", int'(busy), 0);

        // Single requester, done pulse, re-grant after the gap.
        step(8'h01, 1'b0);
        chk("t1_latency", int'(gnt), 0);
        step(8'h01, 1'b0);
        chk("t1_gnt", int'(gnt), 8'h01);
        chk("t1_idx", int'(gnt_idx), 0);
        step(8'h01, 1'b1);
        step(8'h01, 1'b0);
        chk("t1_gap_gnt", int'(gnt), 0);
        chk("t1_gap_busy", int'(busy), 1);
        step(8'h01, 1'b0);
        chk("t1_idle_busy", int'(busy), 0);
        step(8'h01, 1'b0);
        chk("t1_regrant", int'(gnt), 8'h01);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // All requesting, done every cycle: rotation 0..7,0.
        do_reset();
        k = 0;
        for (int i = 0; i < 40 && k < 9; i++) begin
            step(8'hFF, 1'b1);
            if (gnt_valid) begin
                chk("rr_seq", int'(gnt_idx), k % 8);
                k++;
            end
        end
        chk("rr_count", k, 9);

        // Owner 7 then requests on 0 and 6: wrap to 0, then 6.
        do_reset();
        step(8'h80, 1'b0);
        step(8'h80, 1'b0);
        chk("wrap_first", int'(gnt_idx), 7);
        step(8'h41, 1'b0);
        step(8'h41, 1'b0);
        step(8'h41, 1'b0);
        step(8'h41, 1'b0);
        chk("wrap_to0", int'(gnt), 8'h01);
        step(8'h41, 1'b1);
        step(8'h41, 1'b0);
        step(8'h41, 1'b0);
        step(8'h41, 1'b0);
        chk("wrap_then6", int'(gnt), 8'h40);
        chk("wrap_then6_idx", int'(gnt_idx), 6);

        // Withdrawal without done.
        do_reset();
        step(8'h04, 1'b0);
        step(8'h04, 1'b0);
        chk("wd_gnt", int'(gnt), 8'h04);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        chk("wd_gap_gnt", int'(gnt), 0);
        chk("wd_gap_busy", int'(busy), 1);
        step(8'h00, 1'b0);
        chk("wd_idle_busy", int'(busy), 0);
        chk("wd_idx_kept", int'(gnt_idx), 2);

        // Held request, no done: bounded or unbounded grant length.
        do_reset();
        run  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(8'h02, 1'b0);
            if (gnt == 8'h02 && (run == 0 || seen)) begin
                run++;
                seen = 1'b1;
            end else if (seen) begin
                seen = 1'b0;
            end
        end
`ifdef GRANT_TIMEOUT_EN
        chk("hold_len", run, MAX_HOLD);
`else
        chk("hold_len", run, 59);
`endif

        // Asynchronous reset mid-grant, then index 0 first.
        do_reset();
        step(8'h10, 1'b0);
        step(8'h10, 1'b0);
        chk("ar_gnt_before", int'(gnt), 8'h10);
        async_reset_check("ar");
        @(negedge clk);
        req   = 8'h11;
        rst_n = 1'b1;
        step(8'h11, 1'b0);
        chk("ar_after", int'(gnt), 8'h01);

        // Randomized traffic with one asynchronous reset in the middle.
        r = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            step(r, ($urandom_range(0, 4) == 0));
            if (i == 1500) begin
                async_reset_check("rand_ar");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
